mips_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and fetches each 32-bit instruction over a request/ready handshake with instruction memory.
- Presents the latched instruction and its opcode field `op` to the decoder.
- Consumes the decoder's Branch/Jump outputs and the ALU Zero flag to compute the next PC.

---
 rtl/mips_fetch_unit.sv | 106 ++++++++++
 tb/tb_mips_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage for a multi-cycle MIPS core.
// Holds the PC and fetches one instruction word per request/ready handshake.
// Presents the latched word to the main decoder and computes the next PC from
// the decoder's Branch/Jump outputs and the ALU Zero flag.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  input  logic        stall,
  output logic [31:0] retired
);

  typedef enum logic {
    FETCH,
    EXEC
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] branch_off_d;
  logic [31:0] next_pc_d;

  assign pc_plus4_d   = pc_q + 32'd4;
  assign branch_off_d = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Next-PC selection; jump outranks a taken branch, all arithmetic wraps mod 2^32.
  always_comb begin
    next_pc_d = pc_plus4_d;
    if (Jump) begin
      next_pc_d = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
    end else if (Branch && Zero) begin
      next_pc_d = pc_plus4_d + branch_off_d;
    end
  end

  // Two-state fetch/execute sequencer with registered request and valid flags.
  // The request is deliberately held low for the first cycle after reset so a
  // memory still finishing an abandoned access cannot be mistaken for a reply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (req_q && imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= EXEC;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q      <= next_pc_d;
            retired_q <= retired_q + 32'd1;
            state_q   <= FETCH;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_d;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: directed scenarios followed by a
// randomized instruction stream, all checked against a transaction-level model.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Branch;
  logic        Jump;
  logic        Zero;
  logic        stall;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mRetired;

  mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .Branch     (Branch),
    .Jump       (Jump),
    .Zero       (Zero),
    .stall      (stall),
    .retired    (retired)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Architectural next-PC rule expressed with plain arithmetic.
  function automatic logic [31:0] modelNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic br, input logic jmp, input logic zr);
    logic [31:0] seq;
    logic signed [15:0] imm;
    int off;
    seq = curPc + 32'd4;
    imm = word[15:0];
    off = imm;
    if (jmp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (br && zr) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Asserts reset from a negedge, checks the immediate effect, then releases it.
  task automatic applyReset();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_op", {26'd0, op}, 32'd0);
    mPc = RESET_PC;
    mInstr = 32'd0;
    mRetired = 32'd0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_hold_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Fetch phase: memory answers after waitCycles idle cycles with word.
  task automatic applyStimulus(input logic [31:0] word, input int waitCycles);
    for (int i = 0; i <= waitCycles; i++) begin
      checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
      checkOutput("fetch_addr", imem_addr, mPc);
      checkOutput("fetch_valid", {31'd0, instr_valid}, 32'd0);
      checkOutput("fetch_retired", retired, mRetired);
      imem_ready = (i == waitCycles);
      imem_rdata = (i == waitCycles) ? word : $urandom();
      Branch = 1'($urandom_range(0, 1));
      Jump   = 1'($urandom_range(0, 1));
      Zero   = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    mInstr = word;
  endtask

  // Execute phase: holds for stallCycles, then retires with the given controls.
  task automatic execStep(input logic br, input logic jmp, input logic zr, input int stallCycles);
    Branch = br;
    Jump = jmp;
    Zero = zr;
    for (int i = 0; i <= stallCycles; i++) begin
      checkOutput("exec_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("exec_req", {31'd0, imem_req}, 32'd0);
      checkOutput("exec_instr", instr, mInstr);
      checkOutput("exec_op", {26'd0, op}, {26'd0, mInstr[31:26]});
      checkOutput("exec_pc", pc, mPc);
      checkOutput("exec_pc_plus4", pc_plus4, mPc + 32'd4);
      checkOutput("exec_retired", retired, mRetired);
      stall = (i < stallCycles);
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom();
      @(posedge clk);
      @(negedge clk);
    end
    stall = 1'b0;
    mPc = modelNextPc(mPc, mInstr, br, jmp, zr);
    mRetired = mRetired + 32'd1;
  endtask

  initial begin
    logic [31:0] word;
    logic br, jmp, zr;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    Branch = 1'b0;
    Jump = 1'b0;
    Zero = 1'b0;
    stall = 1'b0;
    mPc = RESET_PC;
    mInstr = 32'd0;
    mRetired = 32'd0;
    @(negedge clk);
    applyReset();

    // Zero-wait fetch of an R-type word at address 0.
    applyStimulus(32'h0000_0020, 0);
    execStep(1'b0, 1'b0, 1'b0, 0);
    // Sequential instruction with a two-cycle stall in EXEC.
    applyStimulus(32'h0123_4567, 0);
    execStep(1'b0, 1'b0, 1'b0, 2);
    // Memory answers after three idle cycles at pc=8.
    applyStimulus(32'h8C22_0004, 3);
    execStep(1'b0, 1'b0, 1'b0, 0);
    applyStimulus(32'h0000_0000, 1);
    execStep(1'b0, 1'b0, 1'b0, 0);
    // beq with imm=-2 at pc=0x10, taken then not taken.
    applyStimulus(32'h1000_FFFE, 0);
    execStep(1'b1, 1'b0, 1'b1, 0);
    checkOutput("beq_taken_target", mPc, 32'h0000_000C);
    applyStimulus(32'h0000_0000, 0);
    execStep(1'b0, 1'b0, 1'b0, 0);
    applyStimulus(32'h1000_FFFE, 0);
    execStep(1'b1, 1'b0, 1'b0, 0);
    // Jump chain across 256 MB regions up to pc=0x4000_0000.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h0BFF_FFFF, 0);
      execStep(1'b0, 1'b1, 1'b0, 0);
    end
    applyStimulus(32'h0000_0000, 0);
    execStep(1'b0, 1'b0, 1'b0, 0);
    // Jump and taken branch together: the jump wins.
    applyStimulus(32'h0800_0100, 0);
    execStep(1'b1, 1'b1, 1'b1, 0);
    checkOutput("jump_priority_target", mPc, 32'h4000_0400);
    // Walk up to pc=0xFFFF_FFFC, then let sequential advance wrap to 0.
    for (int k = 0; k < 20 && mPc != 32'hFFFF_FFFC; k++) begin
      applyStimulus(32'h0BFF_FFFF, 0);
      execStep(1'b0, 1'b1, 1'b0, 0);
    end
    applyStimulus(32'h0000_0000, 0);
    execStep(1'b0, 1'b0, 1'b0, 0);
    // Jump from 0 to 0x24.
    applyStimulus(32'h0800_0009, 0);
    execStep(1'b0, 1'b1, 1'b0, 0);

    // Reset during a FETCH at 0x24 with a reply about to arrive.
    for (int i = 0; i < 2; i++) begin
      checkOutput("midfetch_addr", imem_addr, mPc);
      imem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    applyReset();
    imem_ready = 1'b0;
    applyStimulus(32'h2008_0005, 1);
    execStep(1'b0, 1'b0, 1'b0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      word = $urandom();
      br  = ($urandom_range(0, 2) == 0);
      jmp = ($urandom_range(0, 3) == 0);
      zr  = 1'($urandom_range(0, 1));
      applyStimulus(word, $urandom_range(0, 3));
      execStep(br, jmp, zr, $urandom_range(0, 2));
    end
    applyStimulus($urandom(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
